// File: rtl/key_event_pkg.sv
// Shared types for the key gesture decoder: event codes, FSM states and a
// small elaboration-time helper.
package key_event_pkg;

  typedef logic [2:0] evt_code_t;

  localparam evt_code_t EVT_NONE   = 3'd0;
  localparam evt_code_t EVT_CLICK  = 3'd1;
  localparam evt_code_t EVT_DOUBLE = 3'd2;
  localparam evt_code_t EVT_LONG   = 3'd3;
  localparam evt_code_t EVT_REPEAT = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    HELD1,
    GAP,
    HELD2,
    LONG_HELD
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_event_hold.sv
// One-entry valid/ready holding register for decoded events; a load while
// full and not being accepted is discarded and flagged with a drop pulse.
module key_event_hold #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] code_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] code_o,
  output logic         drop_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] code_q, code_d;
  logic         drop_q, drop_d;

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    drop_d  = 1'b0;
    if (load_i && (!valid_q || ready_i)) begin
      valid_d = 1'b1;
      code_d  = code_i;
    end else if (load_i) begin
      drop_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      code_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      drop_q  <= drop_d;
    end
  end

  assign valid_o = valid_q;
  assign code_o  = code_q;
  assign drop_o  = drop_q;

endmodule

// File: rtl/key_event_decoder.sv
// Classifies a debounced key level into CLICK / DOUBLE / LONG events.
// Define KEY_REPEAT_EN to also emit periodic REPEAT events while held after LONG.
module key_event_decoder #(
  parameter int   CLK_FREQ     = 65_000_000,
  parameter int   LONG_MS      = 1000,
  parameter int   GAP_MS       = 250,
  parameter int   REPEAT_MS    = 200,
  parameter logic ACTIVE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_i,
  output logic       key_pressed,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_code,
  output logic       evt_drop
);

  import key_event_pkg::*;

  localparam int CYC_PER_MS = CLK_FREQ / 1000;
  localparam int LONG_CYC   = CYC_PER_MS * LONG_MS;
  localparam int GAP_CYC    = CYC_PER_MS * GAP_MS;
  localparam int REPEAT_CYC = CYC_PER_MS * REPEAT_MS;
  localparam int CNT_W      = $clog2(max3(LONG_CYC, GAP_CYC, REPEAT_CYC));

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYC - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYC - 1);
`endif

  logic             key_q, key_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_press, is_release;
  logic             emit, cnt_rst;
  evt_code_t        emit_code;

  always_comb begin
    key_d      = key_i;
    is_press   = (key_i == ACTIVE_LEVEL) && (key_q != ACTIVE_LEVEL);
    is_release = (key_i != ACTIVE_LEVEL) && (key_q == ACTIVE_LEVEL);
  end

  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_code = EVT_NONE;
    cnt_rst   = 1'b0;
    case (state_q)
      IDLE: if (is_press) state_d = HELD1;
      HELD1: begin
        if (is_release) begin
          state_d = GAP;
        end else if (cnt_q == LONG_TC) begin
          emit      = 1'b1;
          emit_code = EVT_LONG;
          state_d   = LONG_HELD;
        end
      end
      // A press landing on the gap's terminal count still closes the CLICK,
      // but must start the next gesture here since IDLE would miss the edge.
      GAP: begin
        if (cnt_q == GAP_TC) begin
          emit      = 1'b1;
          emit_code = EVT_CLICK;
          state_d   = is_press ? HELD1 : IDLE;
        end else if (is_press) begin
          state_d = HELD2;
        end
      end
      HELD2: begin
        if (is_release) begin
          emit      = 1'b1;
          emit_code = EVT_DOUBLE;
          state_d   = IDLE;
        end
      end
      LONG_HELD: begin
        if (is_release) begin
          state_d = IDLE;
`ifdef KEY_REPEAT_EN
        end else if (cnt_q == REPEAT_TC) begin
          emit      = 1'b1;
          emit_code = EVT_REPEAT;
          cnt_rst   = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts on every state entry and saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || cnt_rst) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q   <= ~ACTIVE_LEVEL;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      key_q   <= key_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_pressed = (key_q == ACTIVE_LEVEL);

  key_event_hold #(
    .W (3)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (emit),
    .code_i  (emit_code),
    .ready_i (evt_ready),
    .valid_o (evt_valid),
    .code_o  (evt_code),
    .drop_o  (evt_drop)
  );

endmodule
